// File: rtl/switch_mcu_ex_pkg.sv
// Shared constants and types for the switch MCU execution-stage controller.
// Unit indices match bit positions of the one-hot unit select.
package switch_mcu_ex_pkg;

   localparam int UNIT_TYPE_R    = 0;
   localparam int UNIT_TYPE_I    = 1;
   localparam int UNIT_LOAD      = 2;
   localparam int UNIT_STORE     = 3;

   localparam int REG_AW         = 5;
   localparam int CNT_W          = 4;
   localparam int LAST_CYCLE_DEF = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ex_state_e;

endpackage

// File: rtl/switch_mcu_ex_rf_mux.sv
// One-hot AND-OR mux: ORs together every bus slice whose select bit is set.
// An all-zero select yields zero, which keeps the register file quiet when idle.
module switch_mcu_ex_rf_mux #(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic [N-1:0]   i_sel,
   input  logic [N*W-1:0] i_bus,
   output logic [W-1:0]   o_y
);

   always_comb begin
      o_y = '0;
      for (int k = 0; k < N; k++) begin
         if (i_sel[k]) begin
            o_y = o_y | i_bus[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/switch_mcu_ex_ctrl.sv
// Execution-stage sequencer: accepts one decoded instruction, steps the shared
// cycle counter through 1..LAST_CYCLE and routes the active unit onto the register file.
module switch_mcu_ex_ctrl
   import switch_mcu_ex_pkg::*;
#(
   parameter int N_UNITS    = 4,
   parameter int LAST_CYCLE = LAST_CYCLE_DEF,
   parameter int XLEN       = 32
) (
   input  logic                      in_clk,
   input  logic                      in_rst,
   input  logic                      in_dec_valid,
   output logic                      out_dec_ready,
   input  logic [N_UNITS-1:0]        in_dec_unit,
   input  logic                      in_stall,
   output logic [CNT_W-1:0]          out_cycle_cnt,
   output logic [N_UNITS-1:0]        out_unit_en,
   output logic                      out_busy,
   output logic                      out_retire,
   output logic                      out_err_sel,
   input  logic [N_UNITS-1:0]        in_unit_ren_1,
   input  logic [REG_AW*N_UNITS-1:0] in_unit_raddr_1,
   input  logic [N_UNITS-1:0]        in_unit_ren_2,
   input  logic [REG_AW*N_UNITS-1:0] in_unit_raddr_2,
   input  logic [N_UNITS-1:0]        in_unit_wen,
   input  logic [REG_AW*N_UNITS-1:0] in_unit_waddr,
   input  logic [XLEN*N_UNITS-1:0]   in_unit_wdata,
   output logic                      out_rf_ren_1,
   output logic                      out_rf_ren_2,
   output logic                      out_rf_wen,
   output logic [REG_AW-1:0]         out_rf_raddr_1,
   output logic [REG_AW-1:0]         out_rf_raddr_2,
   output logic [REG_AW-1:0]         out_rf_waddr,
   output logic [XLEN-1:0]           out_rf_wdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CYCLE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [N_UNITS-1:0] r_sel, w_sel_nxt;
   logic               r_retire, w_retire_nxt;
   logic               r_err, w_err_nxt;
   ex_state_e          w_state;
   logic               w_at_last, w_accept, w_onehot;
   logic [N_UNITS-1:0] w_sel_act;
   logic               w_wen_mux;

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_cnt    <= '0;
         r_sel    <= '0;
         r_retire <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_sel    <= w_sel_nxt;
         r_retire <= w_retire_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign w_state       = (r_cnt == '0) ? ST_IDLE : ST_RUN;
   assign w_at_last     = (r_cnt >= CNT_LAST);
   assign out_dec_ready = (w_state == ST_IDLE) || (w_at_last && !in_stall);
   assign w_accept      = in_dec_valid && out_dec_ready;
   assign w_onehot      = $onehot(in_dec_unit);

   // A non-one-hot select is dropped on accept: counter and select clear, error pulses.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_sel_nxt    = r_sel;
      w_retire_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      case (w_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_onehot) begin
                  w_cnt_nxt = CNT_ONE;
                  w_sel_nxt = in_dec_unit;
               end else begin
                  w_err_nxt = 1'b1;
                  w_sel_nxt = '0;
               end
            end
         end
         ST_RUN: begin
            if (!in_stall) begin
               if (w_at_last) begin
                  w_retire_nxt = 1'b1;
                  w_cnt_nxt    = '0;
                  w_sel_nxt    = '0;
                  if (w_accept) begin
                     if (w_onehot) begin
                        w_cnt_nxt = CNT_ONE;
                        w_sel_nxt = in_dec_unit;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         default: begin
            w_cnt_nxt = '0;
            w_sel_nxt = '0;
         end
      endcase
   end

   assign w_sel_act     = (w_state == ST_RUN) ? r_sel : '0;
   assign out_unit_en   = w_sel_act;
   assign out_cycle_cnt = r_cnt;
   assign out_busy      = (w_state == ST_RUN);
   assign out_retire    = r_retire;
   assign out_err_sel   = r_err;

   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(1)) uRen1 (
      .i_sel (w_sel_act), .i_bus (in_unit_ren_1), .o_y (out_rf_ren_1));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(REG_AW)) uRaddr1 (
      .i_sel (w_sel_act), .i_bus (in_unit_raddr_1), .o_y (out_rf_raddr_1));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(1)) uRen2 (
      .i_sel (w_sel_act), .i_bus (in_unit_ren_2), .o_y (out_rf_ren_2));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(REG_AW)) uRaddr2 (
      .i_sel (w_sel_act), .i_bus (in_unit_raddr_2), .o_y (out_rf_raddr_2));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(1)) uWen (
      .i_sel (w_sel_act), .i_bus (in_unit_wen), .o_y (w_wen_mux));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(REG_AW)) uWaddr (
      .i_sel (w_sel_act), .i_bus (in_unit_waddr), .o_y (out_rf_waddr));
   switch_mcu_ex_rf_mux #(.N(N_UNITS), .W(XLEN)) uWdata (
      .i_sel (w_sel_act), .i_bus (in_unit_wdata), .o_y (out_rf_wdata));

   // x0 is hardwired zero, so a write aimed at it never reaches the register file.
   assign out_rf_wen = w_wen_mux && (out_rf_waddr != '0);

endmodule

// File: doc/switch_mcu_ex_ctrl.md
Name: switch_mcu_ex_ctrl

Overview:
Execution-stage sequencer and register-file port arbiter for the multi-cycle switch MCU core. Accepts one decoded instruction at a time from the decoder via valid/ready, latches the one-hot target execution unit, and drives the shared cycle counter and per-unit enables. Muxes the selected unit's read/write requests onto the single register file. Pulses retire when the instruction's last cycle completes.

Parameters:
N_UNITS, 4, number of execution units sharing the register file (type-R, type-I, load, store by default)
LAST_CYCLE, 5, final cycle_cnt value of an instruction; a unit write registered at cnt 4 is visible at cnt 5
XLEN, 32, register data width

Ports:
in_clk  input  1  core clock
in_rst  input  1  asynchronous active-low reset
in_dec_valid  input  1  decoder has an instruction
out_dec_ready  output  1  controller accepts the instruction this cycle
in_dec_unit  input  N_UNITS  one-hot target unit of the instruction
in_stall  input  1  freeze sequencing (memory wait)
out_cycle_cnt  output  4  shared cycle counter to all units; 0 = idle
out_unit_en  output  N_UNITS  one-hot enable to the active unit
out_busy  output  1  instruction in flight
out_retire  output  1  one-cycle pulse at instruction completion
out_err_sel  output  1  one-cycle pulse: accepted instruction had non-one-hot in_dec_unit
in_unit_ren_1  input  N_UNITS  per-unit read-port-1 enable
in_unit_raddr_1  input  5*N_UNITS  per-unit read-port-1 address, unit k at [5k+4:5k]
in_unit_ren_2  input  N_UNITS  per-unit read-port-2 enable
in_unit_raddr_2  input  5*N_UNITS  per-unit read-port-2 address
in_unit_wen  input  N_UNITS  per-unit write enable
in_unit_waddr  input  5*N_UNITS  per-unit write address
in_unit_wdata  input  XLEN*N_UNITS  per-unit write data
out_rf_ren_1, out_rf_ren_2, out_rf_wen  output  1 each  register-file enables
out_rf_raddr_1, out_rf_raddr_2, out_rf_waddr  output  5 each  register-file addresses
out_rf_wdata  output  XLEN  register-file write data

Behaviour:
- Reset (in_rst low, async): cnt 0, latched sel 0, out_retire 0, out_err_sel 0; therefore out_unit_en 0, out_busy 0, all out_rf_* 0. Reset mid-instruction abandons it; no retire.
- States: IDLE (cnt==0), RUN (cnt 1..LAST_CYCLE). out_busy = (cnt!=0).
- out_dec_ready = IDLE | (cnt==LAST_CYCLE & !in_stall). Combinational.
- Accept = in_dec_valid & out_dec_ready. On accept with $onehot(in_dec_unit): sel<=in_dec_unit, cnt<=1. On accept with non-one-hot (zero or multiple bits): instruction dropped, out_err_sel<=1 next cycle, cnt<=0, sel<=0.
- RUN, in_stall=1: cnt and sel held; unit enable held (units repeat current-cycle action; units are idempotent per cycle).
- RUN, !in_stall, cnt<LAST_CYCLE: cnt<=cnt+1.
- RUN, !in_stall, cnt==LAST_CYCLE: out_retire<=1 (visible next cycle); if accept, back-to-back (cnt<=1, new sel); else cnt<=0, sel<=0.
- out_unit_en = sel when cnt!=0, else 0. out_cycle_cnt = cnt (registered).
- Port mux: combinational AND-OR of unit buses masked by sel; zero when idle. Latency 0 from unit outputs to out_rf_*.
- out_rf_wen = muxed wen & (muxed waddr != 0): writes to x0 suppressed; waddr/wdata still passed through.
- Requests from non-selected units are ignored (masked), even if asserted.
- in_dec_valid while busy and not at last cycle: ready low, decoder holds.
- cnt never exceeds LAST_CYCLE; wrap is to 0 or 1 only.

Decomposition:
- Package switch_mcu_ex_pkg: unit index constants (UNIT_TYPE_R=0, UNIT_TYPE_I=1, UNIT_LOAD=2, UNIT_STORE=3), REG_AW=5, CNT_W=4, default LAST_CYCLE.
- Sub-module switch_mcu_ex_rf_mux: parameterised one-hot AND-OR mux (N, W), instantiated once per bus (ren/raddr x2, wen, waddr, wdata).

Test Plan:
- Reset asserted mid-RUN (cnt=3) -> all outputs 0 immediately; after release, cnt stays 0, no retire.
- Single type-I instruction, in_dec_unit=4'b0010, no stall -> out_cycle_cnt 1,2,3,4,5,0; out_unit_en=4'b0010 for 5 cycles; out_retire pulse one cycle after cnt=5; unit write waddr=7, wdata=0x12345678 appears on out_rf_* same cycle.
- Back-to-back: valid held high with unit 0010 then 0001 -> ready high at cnt=5, second instruction cnt=1 in next cycle, no idle gap, exactly two retire pulses.
- Stall asserted 3 cycles at cnt=2 -> cnt holds 2 for 3 extra cycles, total busy 8 cycles, single retire.
- in_dec_unit=4'b0110 and 4'b0000 -> accepted, out_err_sel pulse, cnt stays 0, no unit enable, no retire.
- Selected unit writes waddr=0 wdata=0xFFFFFFFF -> out_rf_wen 0; non-selected unit asserting ren/wen -> out_rf_* remain 0.
